// File: rtl/dbg_ocimem_engine.sv
// Debug memory engine: turns decoded JTAG ocimem commands into Avalon-MM reads/writes
// with address auto-increment, wait-state timeout and a sticky fault flag.
module dbg_ocimem_engine #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  localparam int unsigned TMO_W = 16;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              mem_read_nxt, mem_write_nxt;
  logic [31:0]       mem_writedata_nxt, mon_dreg_nxt;
  logic              ready_nxt, error_nxt, busy_nxt;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nxt;

  logic any_strobe, multi_strobe, req, done, expired;
  logic unused;

  assign unused       = ^{jdo[37:36], jdo[1:0]};
  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b)
                      | (take_action_ocimem_a & take_no_action_ocimem_a)
                      | (take_action_ocimem_b & take_no_action_ocimem_a);
  assign req          = mem_read | mem_write;
  assign done         = req & ~mem_waitrequest;
  assign expired      = req & mem_waitrequest & (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt         = state;
    addr_nxt          = mem_address;
    mem_read_nxt      = mem_read;
    mem_write_nxt     = mem_write;
    mem_writedata_nxt = mem_writedata;
    mon_dreg_nxt      = MonDReg;
    ready_nxt         = monitor_ready;
    error_nxt         = monitor_error;
    busy_nxt          = busy;
    tmo_cnt_nxt       = tmo_cnt;

    case (state)
      IDLE: begin
        tmo_cnt_nxt   = '0;
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        if (take_action_ocimem_b) begin
          mem_writedata_nxt = jdo[34:3];
          ready_nxt         = 1'b0;
          busy_nxt          = 1'b1;
          state_nxt         = WRITE;
        end else if (take_action_ocimem_a) begin
          addr_nxt = jdo[ADDR_W+1:2];
          if (jdo[35]) error_nxt = 1'b0;
          if (jdo[34]) begin
            ready_nxt = 1'b0;
            busy_nxt  = 1'b1;
            state_nxt = READ;
          end
        end else if (take_no_action_ocimem_a) begin
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = READ;
        end
        // Dropped lower-priority strobes are a fault even if the winner cleared the flag
        if (multi_strobe) error_nxt = 1'b1;
      end

      READ, WRITE: begin
        if (any_strobe) error_nxt = 1'b1;
        if (!req) begin
          // Launch cycle: bus request goes out one edge after acceptance
          mem_read_nxt  = (state == READ);
          mem_write_nxt = (state == WRITE);
          tmo_cnt_nxt   = '0;
        end else if (done) begin
          if (state == READ) mon_dreg_nxt = mem_readdata;
          addr_nxt      = mem_address + ADDR_W'(1);
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          ready_nxt     = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end else if (expired) begin
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          error_nxt     = 1'b1;
          ready_nxt     = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end

      default: begin
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        ready_nxt     = 1'b1;
        busy_nxt      = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  // Registered datapath and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address   <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      busy          <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      mem_address   <= addr_nxt;
      mem_read      <= mem_read_nxt;
      mem_write     <= mem_write_nxt;
      mem_writedata <= mem_writedata_nxt;
      MonDReg       <= mon_dreg_nxt;
      monitor_ready <= ready_nxt;
      monitor_error <= error_nxt;
      busy          <= busy_nxt;
      tmo_cnt       <= tmo_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_dbg_ocimem_engine.sv
// Self-checking bench for dbg_ocimem_engine: scoreboarded bus transactions plus status checks.
module tb_dbg_ocimem_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        act_a, act_b, noact_a;
  logic [7:0]  mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata, mem_readdata, MonDReg;
  logic        mem_waitrequest;
  logic        monitor_ready, monitor_error, busy;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned wait_cfg;
  int unsigned wcnt;
  bit          stuck;
  logic [31:0] rd_data;
  int          cur_len = 0;
  int          last_len = 0;

  dbg_ocimem_engine #(.ADDR_W(8), .TIMEOUT(255)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (act_a),
    .take_action_ocimem_b   (act_b),
    .take_no_action_ocimem_a(noact_a),
    .mem_address            (mem_address),
    .mem_read               (mem_read),
    .mem_write              (mem_write),
    .mem_writedata          (mem_writedata),
    .mem_readdata           (mem_readdata),
    .mem_waitrequest        (mem_waitrequest),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  // Slave model: stall the first wait_cfg cycles of each request, or forever when stuck
  always @(posedge clk) begin
    if (!(mem_read || mem_write)) wcnt <= 0;
    else                          wcnt <= wcnt + 1;
  end
  assign mem_waitrequest = (mem_read || mem_write) && (stuck || (wcnt < wait_cfg));
  assign mem_readdata    = rd_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: pop scoreboard on each completing transfer, track request length
  always @(negedge clk) begin
    if (!reset_n) begin
      cur_len = 0;
    end else if (mem_read || mem_write) begin
      cur_len++;
      check("rw_exclusive", 64'(mem_read & mem_write), 0);
      if (!mem_waitrequest) begin
        check("sb_pending", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          txn_t it;
          it = sb.pop_front();
          check("sb_kind", 64'(mem_write), 64'(it.wr));
          check("sb_addr", 64'(mem_address), 64'(it.addr));
          if (it.wr) check("sb_wdata", 64'(mem_writedata), 64'(it.data));
        end
      end
    end else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len  = 0;
    end
  end

  function automatic logic [37:0] ajdo(input bit clr, input bit rd, input logic [7:0] a);
    logic [37:0] j;
    j       = '0;
    j[35]   = clr;
    j[34]   = rd;
    j[9:2]  = a;
    return j;
  endfunction

  function automatic logic [37:0] wjdo(input logic [31:0] d);
    logic [37:0] j;
    j       = '0;
    j[34:3] = d;
    return j;
  endfunction

  function automatic txn_t mk(input bit wr, input logic [7:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d;
    return t;
  endfunction

  task automatic pulse(input bit a, input bit b, input bit na, input logic [37:0] j);
    @(posedge clk); #1;
    jdo = j; act_a = a; act_b = b; noact_a = na;
    @(posedge clk); #1;
    act_a = 1'b0; act_b = 1'b0; noact_a = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, "_idle"}, 64'(busy), 0);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; jdo = '0; act_a = 1'b0; act_b = 1'b0; noact_a = 1'b0;
    stuck = 1'b0; wait_cfg = 0; rd_data = '0;
    #23;
    check("rst_ready", 64'(monitor_ready), 1);
    check("rst_error", 64'(monitor_error), 0);
    check("rst_busy",  64'(busy), 0);
    check("rst_addr",  64'(mem_address), 0);
    check("rst_mon",   64'(MonDReg), 0);
    check("rst_req",   64'({mem_read, mem_write}), 0);
    check("rst_wdata", 64'(mem_writedata), 0);
    @(negedge clk); reset_n = 1'b1;

    // Address load without read
    pulse(1, 0, 0, ajdo(0, 0, 8'h10));
    @(negedge clk);
    check("lda_addr",  64'(mem_address), 64'h10);
    check("lda_ready", 64'(monitor_ready), 1);
    check("lda_busy",  64'(busy), 0);
    check("lda_req",   64'({mem_read, mem_write}), 0);

    // Zero-wait write, cycle-accurate latency
    sb.push_back(mk(1, 8'h10, 32'hCAFEF00D));
    pulse(0, 1, 0, wjdo(32'hCAFEF00D));
    @(negedge clk);
    check("wr_n0_ready", 64'(monitor_ready), 0);
    check("wr_n0_busy",  64'(busy), 1);
    check("wr_n0_write", 64'(mem_write), 0);
    @(negedge clk);
    check("wr_n1_write", 64'(mem_write), 1);
    check("wr_n1_ready", 64'(monitor_ready), 0);
    @(negedge clk);
    check("wr_n2_ready", 64'(monitor_ready), 1);
    check("wr_n2_busy",  64'(busy), 0);
    check("wr_n2_addr",  64'(mem_address), 64'h11);
    check("wr_n2_write", 64'(mem_write), 0);
    @(negedge clk);
    check("wr_len", 64'(last_len), 1);

    // Load-and-read with three wait states
    wait_cfg = 3; rd_data = 32'hCAFEF00D;
    sb.push_back(mk(0, 8'h10, '0));
    pulse(1, 0, 0, ajdo(0, 1, 8'h10));
    wait_idle("rd3", 50);
    check("rd3_mon",   64'(MonDReg), 64'hCAFEF00D);
    check("rd3_addr",  64'(mem_address), 64'h11);
    check("rd3_error", 64'(monitor_error), 0);
    check("rd3_len",   64'(last_len), 4);

    // Read at top address wraps to zero
    wait_cfg = 0; rd_data = 32'h12345678;
    pulse(1, 0, 0, ajdo(0, 0, 8'hFF));
    sb.push_back(mk(0, 8'hFF, '0));
    pulse(0, 0, 1, '0);
    wait_idle("wrap", 50);
    check("wrap_mon",   64'(MonDReg), 64'h12345678);
    check("wrap_addr",  64'(mem_address), 0);
    check("wrap_error", 64'(monitor_error), 0);

    // Stuck slave: timeout abort, then clear via jdo[35]
    stuck = 1'b1;
    pulse(0, 0, 1, '0);
    wait_idle("tmo", 400);
    check("tmo_error", 64'(monitor_error), 1);
    check("tmo_ready", 64'(monitor_ready), 1);
    check("tmo_mon",   64'(MonDReg), 64'h12345678);
    check("tmo_addr",  64'(mem_address), 0);
    check("tmo_len",   64'(last_len), 255);
    stuck = 1'b0;
    pulse(1, 0, 0, ajdo(1, 0, 8'h20));
    @(negedge clk);
    check("clr_error", 64'(monitor_error), 0);
    check("clr_addr",  64'(mem_address), 64'h20);

    // Write strobe during an in-flight read is ignored and flagged
    wait_cfg = 5; rd_data = 32'hA5A5A5A5;
    sb.push_back(mk(0, 8'h20, '0));
    pulse(0, 0, 1, '0);
    @(negedge clk); @(negedge clk);
    pulse(0, 1, 0, wjdo(32'hDEADBEEF));
    wait_idle("bsy", 50);
    check("bsy_mon",   64'(MonDReg), 64'hA5A5A5A5);
    check("bsy_addr",  64'(mem_address), 64'h21);
    check("bsy_error", 64'(monitor_error), 1);
    check("bsy_wdata", 64'(mem_writedata), 64'hCAFEF00D);

    // Simultaneous a + no_action: only the address load happens
    wait_cfg = 0;
    pulse(1, 0, 0, ajdo(1, 0, 8'h30));
    @(negedge clk);
    check("clr2_error", 64'(monitor_error), 0);
    pulse(1, 0, 1, ajdo(0, 0, 8'h40));
    @(negedge clk);
    check("pri_addr",  64'(mem_address), 64'h40);
    check("pri_error", 64'(monitor_error), 1);
    check("pri_busy",  64'(busy), 0);
    check("pri_ready", 64'(monitor_ready), 1);

    // Simultaneous a + b: write wins, address load dropped
    sb.push_back(mk(1, 8'h40, 32'h11223344));
    pulse(1, 1, 0, wjdo(32'h11223344));
    wait_idle("pri_wr", 50);
    check("pri_wr_addr", 64'(mem_address), 64'h41);

    // Reset mid-read drops the request immediately
    stuck = 1'b1;
    pulse(0, 0, 1, '0);
    repeat (3) @(negedge clk);
    check("rmr_pre_read", 64'(mem_read), 1);
    reset_n = 1'b0;
    #1;
    check("rmr_read",  64'(mem_read), 0);
    check("rmr_ready", 64'(monitor_ready), 1);
    check("rmr_busy",  64'(busy), 0);
    check("rmr_addr",  64'(mem_address), 0);
    stuck = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
